// File: rtl/axis_tg_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator.
package axis_tg_pkg;

    typedef enum logic [1:0] {
        MODE_PKT_CNT = 2'd0,
        MODE_RUN_CNT = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_TAGGED  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/axis_tg_lfsr.sv
// 32-bit Galois LFSR; load restores the seed, step advances one position.
import axis_tg_pkg::*;

module axis_tg_lfsr #(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            value <= SEED;
        end else if (step) begin
            value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream traffic source: configurable length, count, gap and data pattern,
// with start/stop control. Valid/ready: a beat transfers when tvalid && tready at posedge clk.
import axis_tg_pkg::*;

module axis_pattern_gen #(
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter int          GAP_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          cfg_mode,
    input  logic [LEN_W-1:0]    cfg_pkt_len,
    input  logic [LEN_W-1:0]    cfg_pkt_cnt,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic                m_axis_tready,
    output logic                m_axis_tvalid,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    pkts_sent
);

    localparam int HALF = DATA_W / 2;

    state_e             state, state_next;
    mode_e              mode_q;
    logic [LEN_W-1:0]   last_idx_q, pkt_cnt_q, beat_idx, pkt_idx;
    logic [GAP_W-1:0]   gap_q, gap_cnt;
    logic               stop_pend;
    logic [DATA_W-1:0]  run_cnt, pattern;
    logic [31:0]        lfsr_value;
    logic               hs, is_last, start_ok, stop_req, end_run;

    assign m_axis_tvalid = (state == ST_SEND);
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign is_last       = (beat_idx == last_idx_q);
    assign m_axis_tlast  = m_axis_tvalid && is_last;
    assign m_axis_tkeep  = '1;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign start_ok      = (state == ST_IDLE) && start;
    assign stop_req      = stop_pend || stop;
    assign end_run       = stop_req || ((pkt_cnt_q != '0) && (pkt_idx + LEN_W'(1) == pkt_cnt_q));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SEND;
            ST_SEND: begin
                if (hs && is_last) begin
                    if (end_run)           state_next = ST_DONE;
                    else if (gap_q == '0)  state_next = ST_SEND;
                    else                   state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop_req)                            state_next = ST_DONE;
                else if (gap_cnt == gap_q - GAP_W'(1))   state_next = ST_SEND;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Shadow config: only a start accepted in IDLE can change what a run produces.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_PKT_CNT;
            last_idx_q <= '0;
            pkt_cnt_q  <= '0;
            gap_q      <= '0;
        end else if (start_ok) begin
            mode_q     <= mode_e'(cfg_mode);
            last_idx_q <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_W'(1);
            pkt_cnt_q  <= cfg_pkt_cnt;
            gap_q      <= cfg_gap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            beat_idx  <= '0;
            pkt_idx   <= '0;
            pkts_sent <= '0;
            run_cnt   <= '0;
        end else if (hs) begin
            run_cnt <= run_cnt + DATA_W'(1);
            if (is_last) begin
                beat_idx <= '0;
                pkt_idx  <= pkt_idx + LEN_W'(1);
                if (pkts_sent != '1) pkts_sent <= pkts_sent + LEN_W'(1);
            end else begin
                beat_idx <= beat_idx + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_GAP) gap_cnt <= '0;
        else                           gap_cnt <= gap_cnt + GAP_W'(1);
    end

    // Sticky stop: ignored in IDLE, dropped when the run returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE || state_next == ST_IDLE) stop_pend <= 1'b0;
        else if (stop)                                           stop_pend <= 1'b1;
    end

    axis_tg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .step  (hs),
        .value (lfsr_value)
    );

    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_PKT_CNT: pattern = DATA_W'(beat_idx);
            MODE_RUN_CNT: pattern = run_cnt;
            MODE_LFSR:    pattern = DATA_W'(lfsr_value);
            MODE_TAGGED:  pattern = {HALF'(pkt_idx), HALF'(beat_idx)};
            default:      pattern = '0;
        endcase
    end

    assign m_axis_tdata = m_axis_tvalid ? pattern : '0;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: model-driven scoreboard of {tlast, tdata} beats
// plus per-scenario checks of gaps, stalls, done, pkts_sent and reset behaviour.
module tb_axis_pattern_gen;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int GAP_W  = 8;
    localparam int W      = DATA_W + 1;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                stop;
    logic [1:0]          cfg_mode;
    logic [LEN_W-1:0]    cfg_pkt_len;
    logic [LEN_W-1:0]    cfg_pkt_cnt;
    logic [GAP_W-1:0]    cfg_gap;
    logic                m_axis_tready;
    logic                m_axis_tvalid;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [DATA_W/8-1:0] m_axis_tkeep;
    logic                m_axis_tlast;
    logic                busy;
    logic                done;
    logic [LEN_W-1:0]    pkts_sent;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] run1_q[$];
    int          gap_q[$];
    int          done_cnt;
    int          stall_viol;
    bit          timed_out;

    axis_pattern_gen #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .LFSR_SEED(32'hACE1_0001)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .cfg_mode      (cfg_mode),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_cnt   (cfg_pkt_cnt),
        .cfg_gap       (cfg_gap),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_lfsr_step(input logic [31:0] s);
        logic [31:0] taps;
        taps = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    task automatic push_expected(input int mode, input int len, input int npkts);
        int               leff;
        logic [31:0]      run;
        logic [31:0]      lfsr;
        logic [15:0]      ph, bh;
        logic [DATA_W-1:0] d;
        leff = (len == 0) ? 1 : len;
        run  = 32'h0;
        lfsr = 32'hACE1_0001;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < leff; b++) begin
                ph = p[15:0];
                bh = b[15:0];
                case (mode)
                    0:       d = DATA_W'(b);
                    1:       d = run;
                    2:       d = lfsr;
                    default: d = {ph, bh};
                endcase
                exp_q.push_back({(b == leff - 1), d});
                run  = run + 32'h1;
                lfsr = model_lfsr_step(lfsr);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input int mode, input int len, input int cnt, input int gap);
        cfg_mode    = mode[1:0];
        cfg_pkt_len = len[LEN_W-1:0];
        cfg_pkt_cnt = cnt[LEN_W-1:0];
        cfg_gap     = gap[GAP_W-1:0];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: tvalid=%b one clock after start, required 1", m_axis_tvalid);
        end
    endtask

    // Drives tready, optional stop/restart pulses, and scoreboards every handshake until done.
    task automatic drive_stream(input string tag, input int max_cycles, input int ready_pct,
                                input int stop_at, input int restart_at);
        logic [DATA_W-1:0] prev_data;
        logic [W-1:0]      got_v, exp_v;
        bit prev_valid, prev_hs, prev_last, in_gap, seen_done, stop_fired, restart_fired, hs;
        int idle_cnt;
        got_q.delete();
        gap_q.delete();
        done_cnt = 0; stall_viol = 0; timed_out = 1'b1;
        prev_valid = 0; prev_hs = 0; prev_last = 0; prev_data = '0;
        in_gap = 0; seen_done = 0; stop_fired = 0; restart_fired = 0; idle_cnt = 0;
        for (int c = 0; c < max_cycles; c++) begin
            stop  = 1'b0;
            start = 1'b0;
            m_axis_tready = ($urandom_range(0, 99) < ready_pct);
            if (!stop_fired && stop_at >= 0 && got_q.size() == stop_at) begin
                stop = 1'b1;
                stop_fired = 1;
            end
            if (!restart_fired && restart_at >= 0 && got_q.size() == restart_at) begin
                start = 1'b1;
                set_cfg(0, 2, 1, 3);
                restart_fired = 1;
            end
            if (prev_valid && !prev_hs &&
                (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
                stall_viol++;
            if (prev_hs && !prev_last && !m_axis_tvalid) stall_viol++;
            if (m_axis_tvalid) begin
                if (in_gap) gap_q.push_back(idle_cnt);
                in_gap = 0;
            end else if (in_gap) begin
                idle_cnt++;
            end
            if (done) begin
                done_cnt++;
                seen_done = 1;
            end
            hs = m_axis_tvalid && m_axis_tready;
            if (hs) begin
                got_v = {m_axis_tlast, m_axis_tdata};
                got_q.push_back(got_v);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s beat %0d: got %h, none expected", tag, got_q.size() - 1, got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        n_fail++;
                        $display("FAIL %s beat %0d: got {tlast,tdata}=%h, required %h",
                                 tag, got_q.size() - 1, got_v, exp_v);
                    end
                end
                if (m_axis_tlast) begin
                    in_gap = 1;
                    idle_cnt = 0;
                end
            end
            prev_valid = m_axis_tvalid;
            prev_hs    = hs;
            prev_last  = m_axis_tlast;
            prev_data  = m_axis_tdata;
            if (seen_done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        start = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0 || m_axis_tdata !== '0 || pkts_sent !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/last/busy/done=%b tdata=%h pkts_sent=%0d, required all 0",
                     {m_axis_tvalid, m_axis_tlast, busy, done}, m_axis_tdata, pkts_sent);
        end
        n_checks++;
        if (m_axis_tkeep !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_tkeep: got %h, required f", m_axis_tkeep);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_long_counter();
        set_cfg(0, 512, 1, 0);
        push_expected(0, 512, 1);
        pulse_start();
        drive_stream("m0_len512", 2000, 100, -1, -1);
        n_checks++;
        if (timed_out || done_cnt != 1) begin
            n_fail++;
            $display("FAIL m0_done: timed_out=%0d done pulses=%0d, required 0 and 1", timed_out, done_cnt);
        end
        n_checks++;
        if (exp_q.size() != 0 || got_q.size() != 512) begin
            n_fail++;
            $display("FAIL m0_count: got %0d beats, %0d still expected, required 512 and 0", got_q.size(), exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL m0_bubbles: %0d bubbles/violations, required 0", stall_viol);
        end
        n_checks++;
        if (pkts_sent !== 16'd1) begin
            n_fail++;
            $display("FAIL m0_pkts_sent: got %0d, required 1", pkts_sent);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL m0_after_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_gap_running();
        set_cfg(1, 4, 3, 2);
        push_expected(1, 4, 3);
        pulse_start();
        drive_stream("m1_gap2", 200, 100, -1, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL m1_complete: timed_out=%0d left=%0d, required 0 0", timed_out, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (gap_q.size() != 2) begin
            n_fail++;
            $display("FAIL m1_gap_count: got %0d gaps, required 2", gap_q.size());
        end
        foreach (gap_q[i]) begin
            n_checks++;
            if (gap_q[i] != 2) begin
                n_fail++;
                $display("FAIL m1_gap_len: gap %0d is %0d idle cycles, required 2", i, gap_q[i]);
            end
        end
        n_checks++;
        if (pkts_sent !== 16'd3) begin
            n_fail++;
            $display("FAIL m1_pkts_sent: got %0d, required 3", pkts_sent);
        end
    endtask

    task automatic test_random_stall();
        set_cfg(0, 8, 2, 1);
        push_expected(0, 8, 2);
        pulse_start();
        drive_stream("m0_stall", 500, 50, -1, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_complete: timed_out=%0d left=%0d, required 0 0", timed_out, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d hold/drop violations, required 0", stall_viol);
        end
        n_checks++;
        if (pkts_sent !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_pkts_sent: got %0d, required 2", pkts_sent);
        end
    endtask

    task automatic test_lfsr_repeat();
        for (int r = 0; r < 2; r++) begin
            set_cfg(2, 16, 2, 0);
            push_expected(2, 16, 2);
            pulse_start();
            drive_stream("m2_lfsr", 200, 100, -1, -1);
            n_checks++;
            if (timed_out || exp_q.size() != 0 || got_q.size() != 32) begin
                n_fail++;
                $display("FAIL lfsr_complete run %0d: beats=%0d left=%0d, required 32 0", r, got_q.size(), exp_q.size());
                exp_q.delete();
            end
            n_checks++;
            if (got_q.size() == 0 || got_q[0][DATA_W-1:0] !== 32'hACE1_0001) begin
                n_fail++;
                $display("FAIL lfsr_first run %0d: got %h, required ace10001", r,
                         (got_q.size() == 0) ? 32'h0 : got_q[0][DATA_W-1:0]);
            end
            if (r == 0) begin
                run1_q = got_q;
            end else begin
                n_checks++;
                if (got_q != run1_q) begin
                    n_fail++;
                    $display("FAIL lfsr_repeat: run2 (%0d beats) differs from run1 (%0d beats)", got_q.size(), run1_q.size());
                end
            end
        end
    endtask

    task automatic test_stop_tagged();
        set_cfg(3, 4, 0, 0);
        push_expected(3, 4, 6);
        pulse_start();
        drive_stream("m3_stop", 200, 100, 22, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0 || got_q.size() != 24) begin
            n_fail++;
            $display("FAIL stop_complete: timed_out=%0d beats=%0d left=%0d, required 0 24 0",
                     timed_out, got_q.size(), exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== {1'b1, 32'h0005_0003}) begin
            n_fail++;
            $display("FAIL stop_last_beat: got %h, required 100050003",
                     (got_q.size() == 0) ? 33'h0 : got_q[got_q.size() - 1]);
        end
        n_checks++;
        if (pkts_sent !== 16'd6 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL stop_pkts_sent: got %0d done=%0d, required 6 1", pkts_sent, done_cnt);
        end
    endtask

    task automatic test_stop_in_gap();
        set_cfg(0, 2, 0, 5);
        push_expected(0, 2, 1);
        pulse_start();
        drive_stream("gap_stop", 100, 100, 2, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0 || got_q.size() != 2 || gap_q.size() != 0) begin
            n_fail++;
            $display("FAIL gap_stop: timed_out=%0d beats=%0d gaps=%0d, required 0 2 0",
                     timed_out, got_q.size(), gap_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (pkts_sent !== 16'd1) begin
            n_fail++;
            $display("FAIL gap_stop_pkts_sent: got %0d, required 1", pkts_sent);
        end
    endtask

    task automatic test_busy_start();
        set_cfg(1, 4, 2, 0);
        push_expected(1, 4, 2);
        pulse_start();
        drive_stream("busy_start", 100, 100, -1, 3);
        n_checks++;
        if (timed_out || exp_q.size() != 0 || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL busy_start_stream: beats=%0d left=%0d, required 8 0", got_q.size(), exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (gap_q.size() != 1 || gap_q[0] != 0) begin
            n_fail++;
            $display("FAIL busy_start_b2b: gaps=%0d first=%0d, required 1 0",
                     gap_q.size(), (gap_q.size() == 0) ? -1 : gap_q[0]);
        end
        n_checks++;
        if (pkts_sent !== 16'd2) begin
            n_fail++;
            $display("FAIL busy_start_pkts_sent: got %0d, required 2", pkts_sent);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_idle: busy=%b after run, required 0", busy);
        end
    endtask

    task automatic test_len_zero();
        set_cfg(0, 0, 2, 0);
        push_expected(0, 0, 2);
        pulse_start();
        drive_stream("len_zero", 50, 100, -1, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0 || pkts_sent !== 16'd2) begin
            n_fail++;
            $display("FAIL len_zero: left=%0d pkts_sent=%0d, required 0 2", exp_q.size(), pkts_sent);
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset();
        set_cfg(0, 8, 0, 0);
        pulse_start();
        m_axis_tready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0 || m_axis_tdata !== '0 || pkts_sent !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: valid/last/busy/done=%b tdata=%h pkts_sent=%0d, required all 0",
                     {m_axis_tvalid, m_axis_tlast, busy, done}, m_axis_tdata, pkts_sent);
        end
        m_axis_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_cfg(0, 3, 1, 0);
        push_expected(0, 3, 1);
        pulse_start();
        drive_stream("after_reset", 50, 100, -1, -1);
        n_checks++;
        if (timed_out || exp_q.size() != 0 || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL after_reset: beats=%0d left=%0d, required 3 0", got_q.size(), exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        start = 1'b0;
        stop = 1'b0;
        m_axis_tready = 1'b0;
        set_cfg(0, 1, 1, 0);
        test_reset();
        test_long_counter();
        test_gap_running();
        test_random_stall();
        test_lfsr_repeat();
        test_stop_tagged();
        test_stop_in_gap();
        test_busy_start();
        test_len_zero();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
- Parametrised AXI4-Stream master that generates test traffic for DMA/FIFO bring-up and throughput checks. Generalises the fixed 512-beat counter source.
- Configurable data width, packet length, packet count, inter-packet gap and data pattern.
- Handshake is fully AXIS-compliant, with start/stop control and status outputs.
- Sits between the PS GPIO/config registers and the S2MM side of the DMA or stream FIFO.

Parameters:
- DATA_W, 32, tdata width in bits; multiple of 8, minimum 16.
- LEN_W, 16, width of the packet-length and packet-count config fields.
- GAP_W, 8, width of the inter-packet idle-cycle field.
- LFSR_SEED, 32'hACE1_0001, nonzero LFSR load value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- stop  in  1  single-cycle pulse; request to end after the current packet.
- cfg_mode  in  2  pattern select: 0 per-packet counter, 1 running counter, 2 LFSR, 3 tagged.
- cfg_pkt_len  in  LEN_W  beats per packet; 0 is treated as 1.
- cfg_pkt_cnt  in  LEN_W  packets per run; 0 means continuous.
- cfg_gap  in  GAP_W  idle cycles between packets.
- m_axis_tready  in  1  sink ready.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tdata  out  DATA_W  beat data.
- m_axis_tkeep  out  DATA_W/8  byte enables; always all ones.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a run completes.
- pkts_sent  out  LEN_W  packets completed in the current or last run; saturates at all ones.

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, pkts_sent=0, FSM in IDLE, LFSR=LFSR_SEED, all counters 0.
- A handshake is the cycle where tvalid && tready at a rising clk edge.
- AXIS rules:
  - tvalid never depends on tready.
  - Once tvalid is asserted, tvalid, tdata and tlast hold until the handshake.
  - The beat index advances only on a handshake.
- Back-to-back beats within a packet carry no bubbles when tready is held high.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - On start, latch all cfg_* into shadow registers. Later cfg changes have no effect until the next start.
  - Clear beat_idx, pkt_idx, pkts_sent and the running counter; reload the LFSR with LFSR_SEED.
  - Go to SEND; tvalid rises in the next cycle. Latency from start to first tvalid is 1 clock.
- SEND:
  - tvalid=1; tlast=1 when beat_idx == len-1.
  - On a handshake with tlast: increment pkt_idx and pkts_sent, clear beat_idx.
  - Exit from SEND after the last handshake:
    - If stop is pending, or pkt_cnt != 0 and pkt_idx+1 == pkt_cnt: go to DONE.
    - Else if gap == 0: stay in SEND; the next packet's first beat follows immediately.
    - Else: go to GAP.
- GAP: tvalid=0 for exactly gap cycles, then SEND.
- DONE: tvalid=0, done=1 for one cycle, then IDLE.
- stop handling:
  - stop is latched as a sticky request and cleared on entering IDLE.
  - stop in IDLE is ignored.
  - stop in GAP goes to DONE on the next cycle.
  - stop in SEND never truncates a packet; tlast is always delivered.
- start while busy is ignored. start and stop in the same IDLE cycle: start is accepted, stop is ignored.
- Patterns (next value computed at each handshake, all arithmetic modulo 2^DATA_W):
  - Mode 0: tdata = beat_idx, zero-extended; restarts at 0 each packet.
  - Mode 1: tdata = running beat count since start; continues across packets and wraps at 2^DATA_W.
  - Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, stepped once per handshake; tdata = LFSR zero-extended or truncated to DATA_W.
  - Mode 3: tdata upper DATA_W/2 bits = pkt_idx, lower DATA_W/2 bits = beat_idx, each truncated.
- Wrap-around: pkt_idx wraps in continuous mode; pkts_sent saturates.
- Reset asserted mid-packet: all outputs return to reset values on the next edge. No tlast is emitted for the partial packet.

Decomposition:
- Shared package axis_tg_pkg holds:
  - mode enum (MODE_PKT_CNT, MODE_RUN_CNT, MODE_LFSR, MODE_TAGGED);
  - FSM state typedef;
  - LFSR polynomial constant 32'h8020_0003.
- One sub-module, axis_tg_lfsr: 32-bit Galois LFSR with load and step enables.

Test Plan:
- Mode 0, len=512, cnt=1, gap=0, tready=1 → 512 beats with tdata 0..511; tlast only on beat 511; done pulses once; pkts_sent=1.
- Mode 1, len=4, cnt=3, gap=2, tready=1 → tdata 0..11; tlast on beats 3, 7 and 11; exactly 2 idle cycles between packets.
- Mode 0, len=8, tready toggling with a random 50% pattern → tdata and tlast stable while stalled; sequence 0..7 intact; tvalid never drops mid-packet.
- Mode 2, len=16, cnt=2, run twice with the same config → identical LFSR sequences across runs; first beat = 32'hACE1_0001.
- Mode 3, cnt=0 (continuous), len=4, stop pulsed at beat 2 of packet 5 → packet 5 completes with tdata 0x0005_0003 carrying tlast; then done pulses; pkts_sent=6.
- Reset asserted mid-packet, and start pulsed while busy → outputs return to reset values the next cycle; start while busy has no effect; cfg changes mid-run are ignored.
